// File: rtl/pll_reconfig_seq.sv
`timescale 1ns/1ps
// pll_reconfig_seq: applies one of two fractional-N PLL profiles through an
// Avalon-MM reconfig controller, then waits for a stable lock or a timeout.
// Optional feature macro: PLL_CFG_SKIP_SAME_EN -- a request for the profile
// already applied successfully completes at once with no mgmt traffic.
module pll_reconfig_seq #(
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter logic [31:0] M_VAL        = 32'h00000504,
  parameter logic [31:0] NTSC_K       = 32'd702807747,
  parameter logic [31:0] PAL_K        = 32'd429496730
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic        cfg_sel,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest
);

  typedef enum logic [3:0] {
    IDLE, WR_MODE, WR_M, WR_K, WR_START, POLL_RD, POLL_CHK, WAIT_LOCK, DONE, ERR
  } state_e;

  localparam logic [16:0] TO_LIM = 17'(LOCK_TIMEOUT);
  localparam logic [16:0] ST_LIM = 17'(LOCK_STABLE);

  state_e      state_q, state_d;
  logic        sel_q, sel_d;
  logic        poll_q, poll_d;
  logic        cur_sel_q, cur_sel_d;
  logic        cur_valid_q, cur_valid_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [15:0] stab_q, stab_d;
  logic [16:0] to_inc, stab_inc;
  logic [15:0] to_sat, stab_sat;
  logic        to_hit, stab_hit, skip_same;
  logic        unused_bits;

  // Only the status bit of the read word matters; cur_* is only read when
  // the skip feature is built in.
  assign unused_bits = ^{mgmt_readdata[31:1], cur_sel_q, cur_valid_q};

`ifdef PLL_CFG_SKIP_SAME_EN
  assign skip_same = cur_valid_q && (cfg_sel == cur_sel_q);
`else
  assign skip_same = 1'b0;
`endif

  // State and counter registers; reset aborts any access immediately.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      poll_q      <= 1'b0;
      cur_sel_q   <= 1'b0;
      cur_valid_q <= 1'b0;
      to_cnt_q    <= '0;
      stab_q      <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      poll_q      <= poll_d;
      cur_sel_q   <= cur_sel_d;
      cur_valid_q <= cur_valid_d;
      to_cnt_q    <= to_cnt_d;
      stab_q      <= stab_d;
    end
  end

  // Next-state, counters and Moore-style bus/status outputs.
  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    poll_d         = poll_q;
    cur_sel_d      = cur_sel_q;
    cur_valid_d    = cur_valid_q;
    to_cnt_d       = '0;
    stab_d         = '0;
    cfg_busy       = (state_q != IDLE);
    cfg_done       = 1'b0;
    cfg_err        = 1'b0;
    mgmt_write     = 1'b0;
    mgmt_read      = 1'b0;
    mgmt_address   = '0;
    mgmt_writedata = '0;

    // Timeout is judged on the value the counter is about to take, so ERR is
    // entered exactly LOCK_TIMEOUT cycles after WR_START entry.
    to_inc   = {1'b0, to_cnt_q} + 17'd1;
    to_sat   = to_inc[16] ? '1 : to_inc[15:0];
    to_hit   = (to_inc >= TO_LIM);
    stab_inc = {1'b0, stab_q} + 17'd1;
    stab_sat = stab_inc[16] ? '1 : stab_inc[15:0];
    stab_hit = pll_locked && (stab_inc >= ST_LIM);

    case (state_q)
      IDLE: begin
        if (cfg_req) begin
          sel_d   = cfg_sel;
          state_d = skip_same ? DONE : WR_MODE;
        end
      end
      WR_MODE: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h00;
        mgmt_writedata = 32'd1;
        if (!mgmt_waitrequest) state_d = WR_M;
      end
      WR_M: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h04;
        mgmt_writedata = M_VAL;
        if (!mgmt_waitrequest) state_d = WR_K;
      end
      WR_K: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h07;
        mgmt_writedata = sel_q ? PAL_K : NTSC_K;
        if (!mgmt_waitrequest) state_d = WR_START;
      end
      WR_START: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h02;
        mgmt_writedata = 32'd1;
        to_cnt_d       = to_sat;
        if (!mgmt_waitrequest) state_d = POLL_RD;
      end
      POLL_RD: begin
        mgmt_read    = 1'b1;
        mgmt_address = 6'h01;
        to_cnt_d     = to_sat;
        if (to_hit) begin
          state_d = ERR;
        end else if (!mgmt_waitrequest) begin
          poll_d  = mgmt_readdata[0];
          state_d = POLL_CHK;
        end
      end
      POLL_CHK: begin
        to_cnt_d = to_sat;
        if (to_hit) state_d = ERR;
        else        state_d = poll_q ? WAIT_LOCK : POLL_RD;
      end
      WAIT_LOCK: begin
        to_cnt_d = to_sat;
        stab_d   = pll_locked ? stab_sat : '0;
        if (stab_hit)    state_d = DONE;
        else if (to_hit) state_d = ERR;
      end
      DONE: begin
        cfg_done    = 1'b1;
        cur_sel_d   = sel_q;
        cur_valid_d = 1'b1;
        state_d     = IDLE;
      end
      ERR: begin
        cfg_err     = 1'b1;
        cur_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
`timescale 1ns/1ps
// tb_pll_reconfig_seq: directed + randomized runs of the reconfig sequencer
// against a slave responder and a timeline reference model.
module tb_pll_reconfig_seq;

  localparam int TO = 100;
  localparam logic [31:0] M_EXP    = 32'h00000504;
  localparam logic [31:0] NTSC_EXP = 32'd702807747;
  localparam logic [31:0] PAL_EXP  = 32'd429496730;

  logic        refclk = 1'b0;
  logic        rst, cfg_req, cfg_sel, cfg_busy, cfg_done, cfg_err, pll_locked;
  logic [5:0]  mgmt_address;
  logic        mgmt_write, mgmt_read, mgmt_waitrequest;
  logic [31:0] mgmt_writedata, mgmt_readdata;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    int          start;
    int          acc;
    int          hold;
  } txn_t;

  txn_t txq[$];
  txn_t cur;
  bit   in_txn = 1'b0;
  int   stall_left = 0, stall_max = 0, k_stall = 0, poll_left = 0;
  int   wl_start = 1 << 30, strobe_cycles = 0;
  int   lock_mode = 0, drop_len = 1;
  bit   lock_hist[int];
  bit   ref_valid = 1'b0, ref_sel = 1'b0;

  pll_reconfig_seq #(.LOCK_TIMEOUT(TO)) dut (
    .refclk          (refclk),
    .rst             (rst),
    .cfg_req         (cfg_req),
    .cfg_sel         (cfg_sel),
    .cfg_busy        (cfg_busy),
    .cfg_done        (cfg_done),
    .cfg_err         (cfg_err),
    .pll_locked      (pll_locked),
    .mgmt_address    (mgmt_address),
    .mgmt_write      (mgmt_write),
    .mgmt_read       (mgmt_read),
    .mgmt_writedata  (mgmt_writedata),
    .mgmt_readdata   (mgmt_readdata),
    .mgmt_waitrequest(mgmt_waitrequest)
  );

  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Avalon slave: random stalls, protocol checks, logs accepted transfers.
  initial begin
    mgmt_waitrequest = 1'b0;
    mgmt_readdata    = '0;
    forever begin
      @(posedge refclk); #1;
      if (rst) begin
        in_txn = 1'b0;
        mgmt_waitrequest = 1'b0;
      end else if (mgmt_write || mgmt_read) begin
        strobe_cycles++;
        check("wr_rd_exclusive", mgmt_write & mgmt_read, 0);
        if (!in_txn) begin
          in_txn     = 1'b1;
          cur.wr     = mgmt_write;
          cur.addr   = mgmt_address;
          cur.data   = mgmt_writedata;
          cur.start  = cyc;
          cur.hold   = 0;
          stall_left = (mgmt_write && mgmt_address == 6'h07) ? k_stall
                                                            : int'($urandom_range(0, stall_max));
        end else begin
          check("stable_addr", mgmt_address, cur.addr);
          check("stable_data", mgmt_writedata, cur.data);
          check("stable_dir", mgmt_write, cur.wr);
        end
        cur.hold++;
        mgmt_readdata = $urandom();
        if (stall_left > 0) begin
          mgmt_waitrequest = 1'b1;
          mgmt_readdata[0] = (poll_left != 0);
          stall_left--;
        end else begin
          mgmt_waitrequest = 1'b0;
          cur.acc = cyc;
          in_txn  = 1'b0;
          if (!cur.wr) begin
            mgmt_readdata[0] = (poll_left == 0);
            if (poll_left == 0) wl_start = cyc + 2;
            else poll_left--;
          end
          txq.push_back(cur);
        end
      end else begin
        in_txn = 1'b0;
        mgmt_waitrequest = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge refclk); #2;
  endtask

  task automatic drive_lock();
    bit v;
    case (lock_mode)
      0:       v = 1'b1;
      1:       v = 1'b0;
      2:       v = !(cyc >= wl_start + 9 && cyc < wl_start + 9 + drop_len);
      default: v = ($urandom_range(0, 9) != 0);
    endcase
    lock_hist[cyc] = v;
    pll_locked = v;
  endtask

  // One request end to end; the expected outcome comes from the lock history.
  task automatic run_cfg(input bit sel, input int pz, input int lmode, input int kst,
                         input bit poke, output int o_a, output int o_end);
    int a, end_c, busy_bad, s_cyc, exp_c, run, sc, nexp;
    bit exp_done, got_done, got_err, skip;
    bit          e_wr[4];
    logic [5:0]  e_addr[4];
    logic [31:0] e_data[4];
    txq.delete();
    lock_hist.delete();
    poll_left = pz; k_stall = kst; wl_start = 1 << 30; lock_mode = lmode;
    drop_len = $urandom_range(1, 3);
    skip = 1'b0;
`ifdef PLL_CFG_SKIP_SAME_EN
    skip = ref_valid && (ref_sel == sel);
`endif
    a = cyc; cfg_sel = sel; cfg_req = 1'b1; drive_lock();
    end_c = -1; busy_bad = 0; got_done = 1'b0; got_err = 1'b0;
    for (int n = 0; n < 400 && end_c < 0; n++) begin
      step();
      if (cfg_busy !== 1'b1) busy_bad++;
      if (cfg_done === 1'b1 || cfg_err === 1'b1) begin
        end_c = cyc; got_done = cfg_done; got_err = cfg_err;
      end
      cfg_req = poke && (cyc == a + 3);
      cfg_sel = 1'($urandom_range(0, 1));
      drive_lock();
    end
    o_a = a; o_end = end_c;
    check("end_within_budget", end_c >= 0, 1);
    if (end_c < 0) return;
    step();
    check("busy_after_end", cfg_busy, 0);
    check("done_one_cycle", cfg_done, 0);
    check("err_one_cycle", cfg_err, 0);
    exp_done = 1'b0; exp_c = -1;
    if (skip) begin
      exp_done = 1'b1; exp_c = a + 1;
      check("skip_no_access", txq.size(), 0);
    end else begin
      nexp = 4 + pz + 1;
      check("txn_count", txq.size(), nexp);
      if (txq.size() >= nexp) begin
        e_wr   = '{1, 1, 1, 1};
        e_addr = '{6'h00, 6'h04, 6'h07, 6'h02};
        e_data = '{32'd1, M_EXP, (sel ? PAL_EXP : NTSC_EXP), 32'd1};
        for (int i = 0; i < 4; i++) begin
          check("wr_dir", txq[i].wr, e_wr[i]);
          check("wr_addr", txq[i].addr, e_addr[i]);
          check("wr_data", txq[i].data, e_data[i]);
        end
        for (int i = 4; i < nexp; i++) begin
          check("rd_dir", txq[i].wr, 0);
          check("rd_addr", txq[i].addr, 6'h01);
        end
        check("k_hold_cycles", txq[2].hold, kst + 1);
        s_cyc = txq[3].start;
        exp_c = s_cyc + TO; run = 0;
        for (int c = wl_start; c <= s_cyc + TO - 1; c++) begin
          run = (lock_hist.exists(c) && lock_hist[c]) ? run + 1 : 0;
          if (run == 16) begin exp_done = 1'b1; exp_c = c + 1; break; end
        end
      end
    end
    check("outcome_done", got_done, exp_done);
    check("outcome_err", got_err, !exp_done);
    check("end_cycle", end_c, exp_c);
    check("busy_throughout", busy_bad, 0);
    ref_valid = exp_done;
    if (exp_done) ref_sel = sel;
    sc = strobe_cycles;
    repeat (6) step();
    check("quiet_after_end", strobe_cycles - sc, 0);
  endtask

  initial begin
    int a, e, sc;
    bit seen;
    rst = 1'b1; cfg_req = 1'b0; cfg_sel = 1'b0; pll_locked = 1'b0;
    repeat (3) step();
    check("rst_busy", cfg_busy, 0);
    check("rst_done", cfg_done, 0);
    check("rst_err", cfg_err, 0);
    check("rst_write", mgmt_write, 0);
    check("rst_read", mgmt_read, 0);
    check("rst_addr", mgmt_address, 0);
    check("rst_wdata", mgmt_writedata, 0);
    rst = 1'b0;
    step();
    check("idle_busy", cfg_busy, 0);

    // PAL, no stalls, first poll ready: minimal latency
    run_cfg(1'b1, 0, 0, 0, 1'b0, a, e);
    check("min_latency", e - a, 23);
    // K write stalled three cycles
    run_cfg(1'b0, 0, 0, 3, 1'b0, a, e);
    // lock never arrives
    run_cfg(1'b1, 1, 1, 0, 1'b0, a, e);
    // lock drops at WAIT_LOCK cycle 10 then recovers
    run_cfg(1'b0, 0, 2, 0, 1'b0, a, e);
    check("drop_restart", e, wl_start + 9 + drop_len + 16);
    // same profile again: skipped or full sequence depending on build
    run_cfg(1'b0, 0, 0, 0, 1'b0, a, e);
    run_cfg(1'b0, 0, 0, 0, 1'b0, a, e);

    stall_max = 2;
    for (int i = 0; i < 8; i++)
      run_cfg(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 1) != 0) ? 3 : 0, int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), a, e);
    stall_max = 0;

    // reset while polling
    txq.delete(); poll_left = 1000; k_stall = 0; lock_mode = 1;
    cfg_sel = 1'b1; cfg_req = 1'b1; step(); cfg_req = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      step();
      if (mgmt_read === 1'b1) seen = 1'b1;
    end
    check("reached_poll", seen, 1);
    #3 rst = 1'b1;
    #1;
    check("abort_read", mgmt_read, 0);
    check("abort_write", mgmt_write, 0);
    check("abort_addr", mgmt_address, 0);
    check("abort_busy", cfg_busy, 0);
    sc = strobe_cycles;
    step(); step();
    rst = 1'b0; ref_valid = 1'b0;
    repeat (8) step();
    check("no_access_after_rst", strobe_cycles - sc, 0);
    check("idle_after_rst", cfg_busy, 0);
    run_cfg(1'b0, 0, 0, 0, 1'b0, a, e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_seq.md
PLL_RECONFIG_SEQ -- requirements
Module: pll_reconfig_seq

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum refclk cycles to wait for lock after a reconfiguration starts.
REQ-002 SHALL have parameter LOCK_STABLE, default 16: consecutive refclk cycles pll_locked must stay high to count as locked.
REQ-003 SHALL have parameter M_VAL, default 32'h00000504: M-counter word written for both profiles (hi 5, lo 4, odd-duty).
REQ-004 SHALL have parameter NTSC_K, default 32'd702807747: fractional K word for profile 0.
REQ-005 SHALL have parameter PAL_K, default 32'd429496730: fractional K word for profile 1.
REQ-006 refclk  in  1  sole clock, also drives the PLL reconfig management port.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 cfg_req  in  1  single-cycle request to apply the profile on cfg_sel.
REQ-009 cfg_sel  in  1  profile select, 0=NTSC, 1=PAL; sampled only with an accepted cfg_req.
REQ-010 cfg_busy  out  1  high from the cycle after acceptance until the DONE or ERR state is left.
REQ-011 cfg_done  out  1  one-cycle pulse on successful completion.
REQ-012 cfg_err  out  1  one-cycle pulse on lock timeout.
REQ-013 pll_locked  in  1  PLL lock indicator, already synchronous to refclk.
REQ-014 mgmt_address  out  6  reconfig controller register address.
REQ-015 mgmt_write, mgmt_read  out  1 each  Avalon-MM write/read strobes.
REQ-016 mgmt_writedata  out  32  write data; mgmt_readdata  in  32  read data.
REQ-017 mgmt_waitrequest  in  1  Avalon-MM stall.

Function
REQ-018 States SHALL be IDLE, WR_MODE, WR_M, WR_K, WR_START, POLL_RD, POLL_CHK, WAIT_LOCK, DONE, ERR.
REQ-019 IDLE: cfg_req=1 SHALL latch cfg_sel into sel_r and go to WR_MODE; cfg_req outside IDLE SHALL be ignored and not queued.
REQ-020 Each WR_* state SHALL assert mgmt_write with fixed address/data until the cycle mgmt_waitrequest=0, then advance: WR_MODE addr 0x00 data 1 (polling mode); WR_M addr 0x04 data M_VAL; WR_K addr 0x07 data NTSC_K or PAL_K per sel_r; WR_START addr 0x02 data 1.
REQ-021 mgmt_write and mgmt_read SHALL never be high together; address/data SHALL stay stable while waitrequest=1.
REQ-022 POLL_RD SHALL assert mgmt_read at address 0x01 until waitrequest=0, capturing mgmt_readdata[0] that cycle; POLL_CHK SHALL go to WAIT_LOCK if the bit is 1, else back to POLL_RD.
REQ-023 A 16-bit timeout counter SHALL clear on entry to WR_START and increment every cycle through WAIT_LOCK; reaching LOCK_TIMEOUT SHALL force ERR from POLL_RD, POLL_CHK or WAIT_LOCK. It SHALL saturate and never wrap.
REQ-024 WAIT_LOCK: a stable counter SHALL increment while pll_locked=1 and clear when it is 0; reaching LOCK_STABLE SHALL go to DONE.
REQ-025 DONE SHALL pulse cfg_done for one cycle, record sel_r as cur_sel with cur_valid=1, then return to IDLE. ERR SHALL pulse cfg_err for one cycle, clear cur_valid, then return to IDLE.
REQ-026 If a timeout and lock completion occur in the same cycle, DONE SHALL win.
REQ-027 Sequence latency with zero waitrequest SHALL be 4 writes + at least 1 poll read + LOCK_STABLE cycles.

Reset
REQ-028 While rst=1, the state SHALL be IDLE, all outputs 0, mgmt_address 0, counters 0, cur_valid 0 and cur_sel 0.
REQ-029 A rst assertion mid-transaction SHALL abort immediately with no further mgmt access; a new cfg_req after release SHALL restart from WR_MODE.

Configuration
REQ-030 Macro PLL_CFG_SKIP_SAME_EN defined: a cfg_req with cur_valid=1 and cfg_sel==cur_sel SHALL go directly to DONE, performing no mgmt access.
REQ-031 Macro PLL_CFG_SKIP_SAME_EN undefined: every accepted cfg_req SHALL run the full sequence.

Verification
REQ-032 Profile 1 request, waitrequest=0, status=1 on first poll, locked high -> writes (0x00,1),(0x04,0x504),(0x07,429496730),(0x02,1), one read of 0x01, cfg_done after 16 locked cycles.
REQ-033 Waitrequest held high 3 cycles on WR_K -> mgmt_write held 4 cycles with address 0x07 and data stable; exactly one K write accepted.
REQ-034 pll_locked never rises, LOCK_TIMEOUT=100 -> cfg_err pulse 100 cycles after WR_START entry, cfg_done stays 0, cfg_busy drops.
REQ-035 pll_locked drops at cycle 10 of WAIT_LOCK, then recovers -> stable count restarts; cfg_done only after 16 further consecutive locked cycles.
REQ-036 Second profile 0 request after a successful profile 0 run -> with PLL_CFG_SKIP_SAME_EN, cfg_done and no mgmt strobes; without it, the full write sequence repeats.
REQ-037 rst pulsed during POLL_RD -> mgmt_read falls the same cycle, outputs 0, and the next cfg_req begins with a write to 0x00.
